// File: rtl/regbank_arbiter.sv
// Two-requester round-robin arbiter fronting a single-port register bank.
// Each grant runs ACCESS -> ACK -> RELEASE and completes with a 4-phase handshake on req.
module regbank_arbiter #(
  parameter int ADDR_W = 4,
  parameter int REG_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr_rdn0,
  input  logic              wr_rdn1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [REG_W-1:0]  wdata0,
  input  logic [REG_W-1:0]  wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [REG_W-1:0]  rdata0,
  output logic [REG_W-1:0]  rdata1,
  output logic              bank_en,
  output logic              bank_we,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [REG_W-1:0]  bank_wdata,
  input  logic [REG_W-1:0]  bank_rdata,
  output logic              busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_ACK     = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]        r_state;
  logic              r_gnt;
  logic              r_last_gnt;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [REG_W-1:0]  r_wdata;
  logic              r_err;
  logic [REG_W-1:0]  r_rdata0;
  logic [REG_W-1:0]  r_rdata1;

  logic w_gnt_valid;
  logic w_winner;
  logic w_gnt_req;
  logic w_reject;

  // On a tie the requester that did not win last time takes the grant
  assign w_gnt_valid = ena & (req0 | req1);
  assign w_winner    = (req0 & req1) ? ~r_last_gnt : req1;
  assign w_gnt_req   = r_gnt ? req1 : req0;
  assign w_reject    = r_wr & r_addr[ADDR_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_gnt      <= 1'b0;
      r_last_gnt <= 1'b1;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_err      <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_valid) begin
            r_gnt      <= w_winner;
            r_last_gnt <= w_winner;
            r_wr       <= w_winner ? wr_rdn1 : wr_rdn0;
            r_addr     <= w_winner ? addr1   : addr0;
            r_wdata    <= w_winner ? wdata1  : wdata0;
            r_state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_err <= w_reject;
          if (!r_wr) begin
            if (r_gnt) r_rdata1 <= bank_rdata;
            else       r_rdata0 <= bank_rdata;
          end
          r_state <= S_ACK;
        end
        S_ACK: begin
          r_state <= S_RELEASE;
        end
        S_RELEASE: begin
          if (!w_gnt_req) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Writes into the status region never reach the bank
  assign bank_en    = (r_state == S_ACCESS) & ~w_reject;
  assign bank_we    = bank_en & r_wr;
  assign bank_addr  = r_addr;
  assign bank_wdata = r_wdata;

  assign ack0   = (r_state == S_ACK) & ~r_gnt;
  assign ack1   = (r_state == S_ACK) &  r_gnt;
  assign err0   = ack0 & r_err;
  assign err1   = ack1 & r_err;
  assign rdata0 = r_rdata0;
  assign rdata1 = r_rdata1;
  assign busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_regbank_arbiter.sv
// Bench for regbank_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference model; the bank is a small memory owned by the bench.
module tb_regbank_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, ena, req0, req1, wr_rdn0, wr_rdn1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, err0, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic          bank_en, bank_we;
  logic [AW-1:0] bank_addr;
  logic [DW-1:0] bank_wdata, bank_rdata;
  logic          busy;

  int total = 0;
  int bad   = 0;

  regbank_arbiter #(.ADDR_W(AW), .REG_W(DW)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .req0(req0), .req1(req1), .wr_rdn0(wr_rdn0), .wr_rdn1(wr_rdn1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Bank: unwritten locations read a fixed address-derived pattern (address 9 reads 8'h5A)
  bit [DW-1:0] mem   [16];
  bit          mem_v [16];

  function automatic logic [7:0] init_val(input logic [3:0] a);
    return 8'h5A ^ {a, a} ^ 8'h99;
  endfunction

  assign bank_rdata = mem_v[bank_addr] ? mem[bank_addr] : init_val(bank_addr);

  always @(posedge clk) begin
    if (bank_en && bank_we) begin
      mem[bank_addr]   <= bank_wdata;
      mem_v[bank_addr] <= 1'b1;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drop_all;
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset;
    rst = 1'b1; ena = 1'b1; req0 = 1'b1; req1 = 1'b1;
    wr_rdn0 = 1'b0; wr_rdn1 = 1'b0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    step();
    step();
    total++;
    if ({ack0, ack1, err0, err1, bank_en, bank_we, busy} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=%b", {ack0, ack1, err0, err1, bank_en, bank_we, busy}, 7'b0);
    end
    total++;
    if ({bank_addr, bank_wdata, rdata0, rdata1} !== 28'h0) begin
      bad++; $display("FAIL reset_data got=%h exp=%h", {bank_addr, bank_wdata, rdata0, rdata1}, 28'h0);
    end
    req0 = 1'b0; req1 = 1'b0; rst = 1'b0;
    step();
  endtask

  task automatic test_read;
    req0 = 1'b1; wr_rdn0 = 1'b0; addr0 = 4'h9; wdata0 = 8'hFF;
    step();
    total++;
    if ({bank_en, bank_we, bank_addr, busy, ack0} !== {1'b1, 1'b0, 4'h9, 1'b1, 1'b0}) begin
      bad++; $display("FAIL read_access got=%b exp=%b", {bank_en, bank_we, bank_addr, busy, ack0}, {1'b1, 1'b0, 4'h9, 1'b1, 1'b0});
    end
    addr0 = 4'h5; wr_rdn0 = 1'b1;  // post-grant changes must not affect this transaction
    step();
    total++;
    if ({ack0, err0, ack1, err1, bank_en} !== 5'b10000) begin
      bad++; $display("FAIL read_ack got=%b exp=%b", {ack0, err0, ack1, err1, bank_en}, 5'b10000);
    end
    total++;
    if (rdata0 !== 8'h5A) begin
      bad++; $display("FAIL read_data got=%h exp=%h", rdata0, 8'h5A);
    end
    drop_all();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL read_release got=%b exp=%b", busy, 1'b0);
    end
  endtask

  task automatic test_write;
    logic [7:0] exp_r1;
    exp_r1 = init_val(4'h7);
    req1 = 1'b1; wr_rdn1 = 1'b0; addr1 = 4'h7;
    step();
    step();
    total++;
    if (rdata1 !== exp_r1) begin
      bad++; $display("FAIL write_preread got=%h exp=%h", rdata1, exp_r1);
    end
    drop_all();
    req1 = 1'b1; wr_rdn1 = 1'b1; addr1 = 4'h3; wdata1 = 8'hC3;
    step();
    total++;
    if ({bank_en, bank_we, bank_addr, bank_wdata} !== {1'b1, 1'b1, 4'h3, 8'hC3}) begin
      bad++; $display("FAIL write_access got=%h exp=%h", {bank_en, bank_we, bank_addr, bank_wdata}, {1'b1, 1'b1, 4'h3, 8'hC3});
    end
    step();
    total++;
    if ({ack1, err1, ack0, bank_en} !== 4'b1000) begin
      bad++; $display("FAIL write_ack got=%b exp=%b", {ack1, err1, ack0, bank_en}, 4'b1000);
    end
    total++;
    if (rdata1 !== exp_r1) begin
      bad++; $display("FAIL write_rdata_hold got=%h exp=%h", rdata1, exp_r1);
    end
    drop_all();
    total++;
    if (mem[3] !== 8'hC3) begin
      bad++; $display("FAIL write_bank got=%h exp=%h", mem[3], 8'hC3);
    end
  endtask

  task automatic test_reject;
    req0 = 1'b1; wr_rdn0 = 1'b1; addr0 = 4'hA; wdata0 = 8'h55;
    step();
    total++;
    if ({bank_en, bank_we, busy} !== 3'b001) begin
      bad++; $display("FAIL reject_access got=%b exp=%b", {bank_en, bank_we, busy}, 3'b001);
    end
    step();
    total++;
    if ({ack0, err0, ack1, bank_en} !== 4'b1100) begin
      bad++; $display("FAIL reject_ack got=%b exp=%b", {ack0, err0, ack1, bank_en}, 4'b1100);
    end
    total++;
    if (rdata0 !== 8'h5A) begin
      bad++; $display("FAIL reject_rdata got=%h exp=%h", rdata0, 8'h5A);
    end
    drop_all();
    total++;
    if (mem_v[10] !== 1'b0) begin
      bad++; $display("FAIL reject_bank got=%b exp=%b", mem_v[10], 1'b0);
    end
  endtask

  task automatic test_held;
    req0 = 1'b1; wr_rdn0 = 1'b0; addr0 = 4'h3;
    step();
    step();
    total++;
    if ({ack0, rdata0} !== {1'b1, 8'hC3}) begin
      bad++; $display("FAIL held_ack got=%h exp=%h", {ack0, rdata0}, {1'b1, 8'hC3});
    end
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if ({busy, bank_en, ack0} !== 3'b100) begin
        bad++; $display("FAIL held_release[%0d] got=%b exp=%b", i, {busy, bank_en, ack0}, 3'b100);
      end
    end
    req0 = 1'b0;
    step();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL held_idle got=%b exp=%b", busy, 1'b0);
    end
  endtask

  task automatic test_tie;
    int n_ack;
    bit w;
    logic [3:0] exp_a;
    n_ack = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    req0 = 1'b1; wr_rdn0 = 1'b0; addr0 = 4'h1;
    req1 = 1'b1; wr_rdn1 = 1'b0; addr1 = 4'h2;
    for (int k = 0; k < 4; k++) begin
      w = 1'(k & 1);
      exp_a = w ? 4'h2 : 4'h1;
      step(); n_ack += int'(ack0) + int'(ack1);
      total++;
      if ({bank_en, bank_addr} !== {1'b1, exp_a}) begin
        bad++; $display("FAIL tie_grant[%0d] got=%h exp=%h", k, {bank_en, bank_addr}, {1'b1, exp_a});
      end
      step(); n_ack += int'(ack0) + int'(ack1);
      total++;
      if ({ack0, ack1} !== (w ? 2'b01 : 2'b10)) begin
        bad++; $display("FAIL tie_ack[%0d] got=%b exp=%b", k, {ack0, ack1}, (w ? 2'b01 : 2'b10));
      end
      if (w) req1 = 1'b0; else req0 = 1'b0;
      step(); n_ack += int'(ack0) + int'(ack1);
      step(); n_ack += int'(ack0) + int'(ack1);
      if (w) req1 = 1'b1; else req0 = 1'b1;
    end
    drop_all();
    total++;
    if (n_ack != 4) begin
      bad++; $display("FAIL tie_ack_count got=%0d exp=%0d", n_ack, 4);
    end
  endtask

  task automatic test_reset_mid;
    req0 = 1'b1; wr_rdn0 = 1'b0; addr0 = 4'h9;
    step();
    total++;
    if (bank_en !== 1'b1) begin
      bad++; $display("FAIL rstmid_access got=%b exp=%b", bank_en, 1'b1);
    end
    rst = 1'b1;
    step();
    rst = 1'b0; req0 = 1'b0;
    total++;
    if ({ack0, ack1, err0, err1, bank_en, bank_we, busy} !== 7'b0) begin
      bad++; $display("FAIL rstmid_ctrl got=%b exp=%b", {ack0, ack1, err0, err1, bank_en, bank_we, busy}, 7'b0);
    end
    total++;
    if ({bank_addr, bank_wdata, rdata0, rdata1} !== 28'h0) begin
      bad++; $display("FAIL rstmid_data got=%h exp=%h", {bank_addr, bank_wdata, rdata0, rdata1}, 28'h0);
    end
    step();
    total++;
    if ({ack0, busy} !== 2'b00) begin
      bad++; $display("FAIL rstmid_noack got=%b exp=%b", {ack0, busy}, 2'b00);
    end
  endtask

  task automatic test_enable;
    ena = 1'b0; req0 = 1'b1; wr_rdn0 = 1'b0; addr0 = 4'h5;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({busy, bank_en} !== 2'b00) begin
        bad++; $display("FAIL ena_block[%0d] got=%b exp=%b", i, {busy, bank_en}, 2'b00);
      end
    end
    ena = 1'b1;
    step();
    total++;
    if ({bank_en, bank_addr} !== {1'b1, 4'h5}) begin
      bad++; $display("FAIL ena_grant got=%h exp=%h", {bank_en, bank_addr}, {1'b1, 4'h5});
    end
    ena = 1'b0;
    step();
    total++;
    if ({ack0, err0} !== 2'b10) begin
      bad++; $display("FAIL ena_noabort got=%b exp=%b", {ack0, err0}, 2'b10);
    end
    drop_all();
    ena = 1'b1;
  endtask

  // Model: age counts cycles since grant (0 = none, 1 = bank cycle, 2 = ack cycle, 3 = waiting for req drop)
  task automatic test_random;
    int         age, hold [2];
    bit         who, last, cwr, rej;
    logic [3:0] caddr;
    logic [7:0] cwdata;
    logic [7:0] rmem [16];
    logic [7:0] mrd [2];
    bit         rq [2], done [2], rwr [2];
    logic [3:0] rad [2];
    logic [7:0] rwd [2];
    logic [34:0] e, o;
    rst = 1'b1; ena = 1'b0; req0 = 1'b0; req1 = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) rmem[i] = mem_v[i] ? mem[i] : init_val(4'(i));
    age = 0; who = 1'b0; last = 1'b1; cwr = 1'b0; caddr = '0; cwdata = '0;
    for (int r = 0; r < 2; r++) begin
      mrd[r] = '0; rq[r] = 1'b0; done[r] = 1'b0; hold[r] = 0;
      rwr[r] = 1'b0; rad[r] = '0; rwd[r] = '0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      step();
      if (age == 0) begin
        if (ena && (rq[0] || rq[1])) begin
          who = (rq[0] && rq[1]) ? !last : rq[1];
          last = who; cwr = rwr[who]; caddr = rad[who]; cwdata = rwd[who]; age = 1;
        end
      end else if (age == 1) begin
        if (!cwr) mrd[who] = rmem[caddr];
        else if (!caddr[3]) rmem[caddr] = cwdata;
        age = 2;
      end else if (age == 2) begin
        age = 3;
      end else if (!rq[who]) begin
        age = 0;
      end
      rej = cwr && caddr[3];
      e = {age == 2 && !who, age == 2 && who, age == 2 && !who && rej, age == 2 && who && rej,
           age == 1 && !rej, age == 1 && !rej && cwr, age != 0, caddr, cwdata, mrd[0], mrd[1]};
      o = {ack0, ack1, err0, err1, bank_en, bank_we, busy, bank_addr, bank_wdata, rdata0, rdata1};
      total++;
      if (o !== e) begin
        bad++; $display("FAIL random[%0d] got=%h exp=%h", cyc, o, e);
      end
      ena = ($urandom_range(0, 3) != 0);
      for (int r = 0; r < 2; r++) begin
        if (age == 1 && who == r) begin
          rwr[r] = 1'($urandom_range(0, 1)); rad[r] = 4'($urandom_range(0, 15)); rwd[r] = 8'($urandom);
        end
        if (age == 2 && who == r) begin
          done[r] = 1'b1; hold[r] = int'($urandom_range(0, 3));
        end
        if (done[r]) begin
          if (hold[r] == 0) begin rq[r] = 1'b0; done[r] = 1'b0; end
          else hold[r]--;
        end else if (!rq[r] && !(age >= 2 && who == r) && $urandom_range(0, 2) == 0) begin
          rq[r] = 1'b1; rwr[r] = 1'($urandom_range(0, 1));
          rad[r] = 4'($urandom_range(0, 15)); rwd[r] = 8'($urandom);
        end
      end
      req0 = rq[0]; wr_rdn0 = rwr[0]; addr0 = rad[0]; wdata0 = rwd[0];
      req1 = rq[1]; wr_rdn1 = rwr[1]; addr1 = rad[1]; wdata1 = rwd[1];
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_reject();
    test_held();
    test_tie();
    test_reset_mid();
    test_enable();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
